calc_enc_seq: RTL and testbench

// - Sequential, debounced successor to the combinational button-to-ALU-op encoder of the calculator top level.
// - Synchronises and debounces btnc/btnl/btnr/btnd and accumulates a button "chord" so the three buttons need not go down together.
// - On a btnd press, encodes the chord into a 4-bit alu_op and issues it to the ALU/accumulator through a valid/ready handshake.

---
 rtl/calc_pkg.sv | 36 +++
 rtl/calc_enc_seq_if.sv | 10 +
 rtl/calc_debounce.sv | 59 +++++
 rtl/calc_enc_seq.sv | 119 +++++++++++
 tb/tb_calc_enc_seq.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the sequential calculator button encoder:
// ALU opcode constants, FSM state encoding and the chord-to-opcode table.
package calc_pkg;

    // ALU opcodes indexed by the {c,l,r} chord that selects them
    localparam logic [3:0] OP_CH_001 = 4'b0001;
    localparam logic [3:0] OP_CH_010 = 4'b0100;
    localparam logic [3:0] OP_CH_011 = 4'b1001;
    localparam logic [3:0] OP_CH_100 = 4'b0010;
    localparam logic [3:0] OP_CH_101 = 4'b0110;
    localparam logic [3:0] OP_CH_110 = 4'b1010;
    localparam logic [3:0] OP_CH_111 = 4'b0101;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_REL = 2'd2
    } state_t;

    // Fixed chord -> alu_op table; an empty chord is never issued, so it maps to 0
    function automatic logic [3:0] enc(input logic [2:0] ch);
        logic [3:0] op;
        case (ch)
            3'b001:  op = OP_CH_001;
            3'b010:  op = OP_CH_010;
            3'b011:  op = OP_CH_011;
            3'b100:  op = OP_CH_100;
            3'b101:  op = OP_CH_101;
            3'b110:  op = OP_CH_110;
            3'b111:  op = OP_CH_111;
            default: op = 4'b0000;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/calc_enc_seq_if.sv
// Operation handshake between the button encoder (master) and the
// ALU/accumulator (slave). alu_op is meaningful only while op_valid is high.
interface calc_enc_seq_if;
    logic       op_valid;
    logic       op_ready;
    logic [3:0] alu_op;

    modport master (output op_valid, output alu_op, input  op_ready);
    modport slave  (input  op_valid, input  alu_op, output op_ready);
endinterface

// File: rtl/calc_debounce.sv
// Synchroniser plus level debouncer for one raw push-button input.
// The debounced level only changes after the synchronised input has
// disagreed with it for DEBOUNCE_CYCLES consecutive clock edges.
module calc_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_bit;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   db_q, db_d;

    assign sync_bit = sync_q[SYNC_STAGES-1];
    assign dout     = db_q;

    // Synchroniser chain: raw input enters at bit 0, oldest sample at the top
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    // Disagreement counter: any agreement restarts the count
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (sync_bit == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            db_d  = sync_bit;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Debounce state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

endmodule

// File: rtl/calc_enc_seq.sv
// Sequential button-to-ALU-op encoder. Buttons c/l/r are debounced and
// OR-accumulated into a chord while idle; a debounced btnd press encodes
// the chord and offers it to the ALU over a valid/ready handshake.
module calc_enc_seq
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  btnc,
    input  logic                  btnl,
    input  logic                  btnr,
    input  logic                  btnd,
    calc_enc_seq_if.master        op_if,
    output logic [2:0]            chord,
    output logic                  busy
);

    // Bit order {c,l,r,d} so the top three bits line up with the chord
    logic [3:0] raw_btn;
    logic [3:0] db_btn;
    logic [2:0] db_chord;
    logic       db_btnd;

    assign raw_btn  = {btnc, btnl, btnr, btnd};
    assign db_chord = db_btn[3:1];
    assign db_btnd  = db_btn[0];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_db
            calc_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .SYNC_STAGES     (SYNC_STAGES)
            ) u_db (
                .clk   (clk),
                .reset (reset),
                .din   (raw_btn[gi]),
                .dout  (db_btn[gi])
            );
        end
    endgenerate

    state_t     state_q, state_d;
    logic       btnd_prev_q;
    logic       btnd_rise;
    logic [2:0] chord_q, chord_d;
    logic [2:0] next_chord;
    logic       op_valid_q, op_valid_d;
    logic [3:0] alu_op_q, alu_op_d;

    assign btnd_rise  = db_btnd & ~btnd_prev_q;
    // Value the chord latch would take this edge in IDLE; using it lets a
    // chord bit that settles together with btnd still be included
    assign next_chord = chord_q | db_chord;

    assign op_if.op_valid = op_valid_q;
    assign op_if.alu_op   = alu_op_q;
    assign chord          = chord_q;
    assign busy           = (state_q != ST_IDLE);

    // Next-state, chord accumulation and issue decisions
    always_comb begin
        state_d    = state_q;
        chord_d    = chord_q;
        op_valid_d = op_valid_q;
        alu_op_d   = alu_op_q;
        case (state_q)
            ST_IDLE: begin
                chord_d = next_chord;
                if (btnd_rise) begin
                    if (next_chord != 3'b000) begin
                        op_valid_d = 1'b1;
                        alu_op_d   = enc(next_chord);
                        state_d    = ST_ISSUE;
                    end else begin
                        // Empty chord: swallow the press until btnd is released
                        state_d = ST_WAIT_REL;
                    end
                end
            end
            ST_ISSUE: begin
                // alu_op is deliberately left holding its last value
                if (op_if.op_ready) begin
                    op_valid_d = 1'b0;
                    chord_d    = 3'b000;
                    state_d    = ST_WAIT_REL;
                end
            end
            ST_WAIT_REL: begin
                if (!db_btnd) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, edge-detect and output registers; reset wins over any handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            btnd_prev_q <= 1'b0;
            chord_q     <= 3'b000;
            op_valid_q  <= 1'b0;
            alu_op_q    <= 4'b0000;
        end else begin
            state_q     <= state_d;
            btnd_prev_q <= db_btnd;
            chord_q     <= chord_d;
            op_valid_q  <= op_valid_d;
            alu_op_q    <= alu_op_d;
        end
    end

endmodule

// File: tb/tb_calc_enc_seq.sv
// Directed bench for calc_enc_seq with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_calc_enc_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       btnc, btnl, btnr, btnd;
    logic [2:0] chord;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [3:0] exp_tab [8];

    calc_enc_seq_if op_bus ();

    calc_enc_seq #(
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btnc  (btnc),
        .btnl  (btnl),
        .btnr  (btnr),
        .btnd  (btnd),
        .op_if (op_bus.master),
        .chord (chord),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("vec %0d %s observed %0h expected %0h", vectors, tag, obs, exp);
    endtask

    // Count edges until op_valid rises, bounded at 40
    task automatic wait_valid(output int n);
        n = 0;
        while (op_bus.op_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic release_all();
        btnc = 1'b0;
        btnl = 1'b0;
        btnr = 1'b0;
        btnd = 1'b0;
        repeat (12) tick();
    endtask

    task automatic issue_chord(input logic [2:0] c, input logic [3:0] exp_op);
        int n;
        btnc = c[2];
        btnl = c[1];
        btnr = c[0];
        repeat (8) tick();
        btnd = 1'b1;
        wait_valid(n);
        check("sweep_valid", 32'(op_bus.op_valid), 32'd1);
        check("sweep_op",    32'(op_bus.alu_op),   32'(exp_op));
        check("sweep_chord", 32'(chord),           32'(c));
        tick();
        check("sweep_pulse", 32'(op_bus.op_valid), 32'd0);
        release_all();
        check("sweep_idle",  32'(busy),            32'd0);
    endtask

    initial begin
        int  n;
        logic seen;
        logic stable;

        exp_tab[0] = 4'b0000; exp_tab[1] = 4'b0001;
        exp_tab[2] = 4'b0100; exp_tab[3] = 4'b1001;
        exp_tab[4] = 4'b0010; exp_tab[5] = 4'b0110;
        exp_tab[6] = 4'b1010; exp_tab[7] = 4'b0101;

        // Reset state
        reset = 1'b1;
        btnc = 1'b0; btnl = 1'b0; btnr = 1'b0; btnd = 1'b0;
        op_bus.op_ready = 1'b1;
        repeat (3) tick();
        check("rst_valid", 32'(op_bus.op_valid), 32'd0);
        check("rst_op",    32'(op_bus.alu_op),   32'd0);
        check("rst_chord", 32'(chord),           32'd0);
        check("rst_busy",  32'(busy),            32'd0);
        reset = 1'b0;
        tick();

        // btnl+btnr held, then btnd: 7-edge latency, one-cycle pulse
        btnl = 1'b1; btnr = 1'b1;
        repeat (8) tick();
        check("lat_chord_acc", 32'(chord), 32'd3);
        btnd = 1'b1;
        wait_valid(n);
        check("lat_edges", 32'(n),                32'd7);
        check("lat_op",    32'(op_bus.alu_op),    32'b1001);
        check("lat_chord", 32'(chord),            32'd3);
        tick();
        check("lat_pulse",       32'(op_bus.op_valid), 32'd0);
        check("lat_chord_clear", 32'(chord),           32'd0);
        check("lat_busy_held",   32'(busy),            32'd1);
        release_all();
        check("lat_idle", 32'(busy), 32'd0);

        // All seven non-zero chords
        for (int c = 1; c < 8; c++) begin
            issue_chord(3'(c), exp_tab[c]);
        end

        // btnd with empty chord: never issues, busy while held
        btnd = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            tick();
            if (op_bus.op_valid === 1'b1) seen = 1'b1;
        end
        check("empty_no_issue", 32'(seen), 32'd0);
        check("empty_busy",     32'(busy), 32'd1);
        release_all();
        check("empty_idle",     32'(busy), 32'd0);

        // Accumulate c then r separately -> chord 101
        btnc = 1'b1; repeat (8) tick();
        btnc = 1'b0; repeat (8) tick();
        btnr = 1'b1; repeat (8) tick();
        btnr = 1'b0; repeat (8) tick();
        check("acc_chord", 32'(chord), 32'b101);
        btnd = 1'b1;
        wait_valid(n);
        check("acc_valid", 32'(op_bus.op_valid), 32'd1);
        check("acc_op",    32'(op_bus.alu_op),   32'b0110);
        release_all();

        // Back-pressure: op_ready low for 10 cycles
        op_bus.op_ready = 1'b0;
        btnl = 1'b1;
        repeat (8) tick();
        btnd = 1'b1;
        wait_valid(n);
        stable = 1'b1;
        repeat (10) begin
            tick();
            if (op_bus.op_valid !== 1'b1 || op_bus.alu_op !== 4'b0100) stable = 1'b0;
        end
        check("stall_stable", 32'(stable), 32'd1);
        op_bus.op_ready = 1'b1;
        tick();
        check("stall_release", 32'(op_bus.op_valid), 32'd0);
        seen = 1'b0;
        repeat (15) begin
            tick();
            if (op_bus.op_valid === 1'b1) seen = 1'b1;
        end
        check("stall_no_reissue", 32'(seen), 32'd0);
        release_all();

        // Three-cycle glitch on btnc is dropped
        btnc = 1'b1;
        repeat (3) tick();
        btnc = 1'b0;
        repeat (6) tick();
        btnd = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            tick();
            if (op_bus.op_valid === 1'b1) seen = 1'b1;
        end
        check("glitch_no_issue", 32'(seen),  32'd0);
        check("glitch_chord",    32'(chord), 32'd0);
        release_all();

        // Reset in ISSUE, then btnd still held is a fresh press
        op_bus.op_ready = 1'b0;
        btnr = 1'b1;
        repeat (8) tick();
        btnd = 1'b1;
        wait_valid(n);
        check("rstiss_valid_before", 32'(op_bus.op_valid), 32'd1);
        reset = 1'b1;
        tick();
        check("rstiss_valid", 32'(op_bus.op_valid), 32'd0);
        check("rstiss_op",    32'(op_bus.alu_op),   32'd0);
        check("rstiss_chord", 32'(chord),           32'd0);
        check("rstiss_busy",  32'(busy),            32'd0);
        reset = 1'b0;
        op_bus.op_ready = 1'b1;
        wait_valid(n);
        check("rstiss_repress_edges", 32'(n),              32'd7);
        check("rstiss_repress_op",    32'(op_bus.alu_op),  32'b0001);
        release_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
